// File: rtl/usr_cmd_sequencer_if.sv
// Command handshake bundle between a command source and the sequencer.
// The source drives op/data/cnt with valid; the sequencer returns ready.
interface usr_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Turns LOAD/SHR/SHL/LOAD_SHR commands into shift-register sel/parin strobes and tracks the register in mirror.
// Latency: done 2 cycles after a LOAD, n+1 after a shift of n, n+2 after LOAD_SHR; cmd_ready only in IDLE.
module usr_cmd_sequencer (
  input  logic                      clk,
  input  logic                      clr,
  usr_cmd_sequencer_if.slave        cmd,
  output logic [1:0]                sel,
  output logic [3:0]                parin,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                mirror
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_LDSHR = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_q, op_nxt;
  logic [2:0] cnt_q;
  logic [2:0] rem, rem_nxt;
  logic [1:0] sel_nxt;
  logic       accept;

  assign cmd.cmd_ready = (state == IDLE);
  assign accept        = cmd.cmd_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    op_nxt    = accept ? cmd.cmd_op : op_q;
    sel_nxt   = SEL_HOLD;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_LOAD || cmd.cmd_op == OP_LDSHR) begin
            state_nxt = LOAD;
          end else if (cmd.cmd_cnt != 3'd0) begin
            state_nxt = SHIFT;
            rem_nxt   = cmd.cmd_cnt;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        if (op_q == OP_LDSHR && cnt_q != 3'd0) begin
          state_nxt = SHIFT;
          rem_nxt   = cnt_q;
        end else begin
          state_nxt = DONE;
        end
      end
      SHIFT: begin
        rem_nxt = rem - 3'd1;
        if (rem == 3'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they are clean for the whole state cycle.
    case (state_nxt)
      LOAD:    sel_nxt = SEL_LOAD;
      SHIFT:   sel_nxt = (op_nxt == OP_SHL) ? SEL_SHL : SEL_SHR;
      default: sel_nxt = SEL_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      rem    <= 3'd0;
      op_q   <= OP_LOAD;
      cnt_q  <= 3'd0;
      parin  <= 4'd0;
      sel    <= SEL_HOLD;
      done   <= 1'b0;
      busy   <= 1'b0;
      mirror <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      op_q  <= op_nxt;
      sel   <= sel_nxt;
      done  <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE);
      if (accept) begin
        cnt_q <= cmd.cmd_cnt;
        parin <= cmd.cmd_data;
      end
      // sel already reflects the current state, so it directly selects the mirror update.
      case (sel)
        SEL_LOAD: mirror <= parin;
        SEL_SHR:  mirror <= {1'b0, mirror[3:1]};
        SEL_SHL:  mirror <= {mirror[2:0], 1'b0};
        default:  mirror <= mirror;
      endcase
    end
  end

  // OP_SHR is the implicit non-LOAD, non-SHL case above.
  logic unused_op_shr;
  assign unused_op_shr = (OP_SHR == 2'b01);

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for usr_cmd_sequencer: hand-computed sel/done/mirror sequences per command.
module tb_usr_cmd_sequencer;

  logic       clk;
  logic       clr;
  logic [1:0] sel;
  logic [3:0] parin;
  logic       busy;
  logic       done;
  logic [3:0] mirror;

  int n_assert = 0;
  int n_fail   = 0;

  usr_cmd_sequencer_if cmd_if ();

  usr_cmd_sequencer dut (
    .clk    (clk),
    .clr    (clr),
    .cmd    (cmd_if),
    .sel    (sel),
    .parin  (parin),
    .busy   (busy),
    .done   (done),
    .mirror (mirror)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge and settle; outputs then show the cycle after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] d, input logic [2:0] c);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_cnt   = c;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic dn,
                         input logic bz, input logic rd, input logic [3:0] m);
    chk({tag, ".sel"},    {6'd0, sel},            {6'd0, s});
    chk({tag, ".done"},   {7'd0, done},           {7'd0, dn});
    chk({tag, ".busy"},   {7'd0, busy},           {7'd0, bz});
    chk({tag, ".ready"},  {7'd0, cmd_if.cmd_ready}, {7'd0, rd});
    chk({tag, ".mirror"}, {4'd0, mirror},         {4'd0, m});
  endtask

  initial begin
    drive(1'b0, 2'b00, 4'h0, 3'd0);
    clr = 1'b0;
    #2;
    chk_out("rst", 2'b00, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("rst.parin", {4'd0, parin}, 8'h00);
    tick();
    tick();
    clr = 1'b1;

    // LOAD 1011
    drive(1'b1, 2'b00, 4'b1011, 3'd0);
    tick();
    drive(1'b0, 2'b10, 4'b1111, 3'd5);
    chk_out("ld.k1", 2'b11, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("ld.parin", {4'd0, parin}, 8'h0b);
    tick();
    chk_out("ld.k2", 2'b00, 1'b1, 1'b1, 1'b0, 4'b1011);
    tick();
    chk_out("ld.k3", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1011);

    // LOAD_SHR 1011 cnt 2, inputs scrambled after acceptance
    drive(1'b1, 2'b11, 4'b1011, 3'd2);
    tick();
    drive(1'b0, 2'b10, 4'b0100, 3'd7);
    chk_out("lsr.k1", 2'b11, 1'b0, 1'b1, 1'b0, 4'b1011);
    tick();
    chk_out("lsr.k2", 2'b01, 1'b0, 1'b1, 1'b0, 4'b1011);
    chk("lsr.parin", {4'd0, parin}, 8'h0b);
    tick();
    chk_out("lsr.k3", 2'b01, 1'b0, 1'b1, 1'b0, 4'b0101);
    tick();
    chk_out("lsr.k4", 2'b00, 1'b1, 1'b1, 1'b0, 4'b0010);
    tick();
    chk_out("lsr.k5", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0010);

    // Reload 1011, then SHL cnt 3
    drive(1'b1, 2'b00, 4'b1011, 3'd0);
    tick();
    drive(1'b0, 2'b00, 4'b0000, 3'd0);
    tick();
    tick();
    chk_out("shl.pre", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1011);
    drive(1'b1, 2'b10, 4'b0000, 3'd3);
    tick();
    drive(1'b0, 2'b01, 4'b0000, 3'd1);
    chk_out("shl.k1", 2'b10, 1'b0, 1'b1, 1'b0, 4'b1011);
    tick();
    chk_out("shl.k2", 2'b10, 1'b0, 1'b1, 1'b0, 4'b0110);
    tick();
    chk_out("shl.k3", 2'b10, 1'b0, 1'b1, 1'b0, 4'b1100);
    tick();
    chk_out("shl.k4", 2'b00, 1'b1, 1'b1, 1'b0, 4'b1000);
    tick();
    chk_out("shl.k5", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1000);

    // SHR cnt 0
    drive(1'b1, 2'b01, 4'b0000, 3'd0);
    tick();
    drive(1'b0, 2'b00, 4'b0000, 3'd0);
    chk_out("shr0.k1", 2'b00, 1'b1, 1'b1, 1'b0, 4'b1000);
    tick();
    chk_out("shr0.k2", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1000);

    // valid held high: LOAD 0110 then SHR cnt 1
    drive(1'b1, 2'b00, 4'b0110, 3'd0);
    tick();
    drive(1'b1, 2'b01, 4'b1111, 3'd1);
    chk_out("q.k1", 2'b11, 1'b0, 1'b1, 1'b0, 4'b1000);
    tick();
    chk_out("q.k2", 2'b00, 1'b1, 1'b1, 1'b0, 4'b0110);
    tick();
    chk_out("q.k3", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0110);
    tick();
    drive(1'b0, 2'b00, 4'b0000, 3'd0);
    chk_out("q.k4", 2'b01, 1'b0, 1'b1, 1'b0, 4'b0110);
    chk("q.parin", {4'd0, parin}, 8'h0f);
    tick();
    chk_out("q.k5", 2'b00, 1'b1, 1'b1, 1'b0, 4'b0011);
    tick();
    chk_out("q.k6", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0011);

    // SHL cnt 7 aborted by reset during SHIFT
    drive(1'b1, 2'b10, 4'b0000, 3'd7);
    tick();
    drive(1'b0, 2'b00, 4'b0000, 3'd0);
    tick();
    tick();
    chk_out("ab.k3", 2'b10, 1'b0, 1'b1, 1'b0, 4'b1100);
    #2;
    clr = 1'b0;
    #1;
    chk_out("ab.rst", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000);
    chk("ab.parin", {4'd0, parin}, 8'h00);
    tick();
    tick();
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ab.nodone", {7'd0, done}, 8'h00);
    end
    chk_out("ab.idle", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000);

    // LOAD 0101 after the abort
    drive(1'b1, 2'b00, 4'b0101, 3'd0);
    tick();
    drive(1'b0, 2'b00, 4'b0000, 3'd0);
    chk_out("ld2.k1", 2'b11, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("ld2.parin", {4'd0, parin}, 8'h05);
    tick();
    chk_out("ld2.k2", 2'b00, 1'b1, 1'b1, 1'b0, 4'b0101);
    tick();
    chk_out("ld2.k3", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_cmd_sequencer.md
USR_CMD_SEQUENCER -- requirements
Module: usr_cmd_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-004 The block SHALL have port cmd_ready, output, 1 bit: sequencer can accept a command.
REQ-005 The block SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 SHR, 10 SHL, 11 LOAD_SHR.
REQ-006 The block SHALL have port cmd_data, input, 4 bits: parallel load value.
REQ-007 The block SHALL have port cmd_cnt, input, 3 bits: shift count, 0-7.
REQ-008 The block SHALL have port sel, output, 2 bits: shift-register mode (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-009 The block SHALL have port parin, output, 4 bits: parallel data to the shift register.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port mirror, output, 4 bits: predicted shift-register contents.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op, cmd_data and cmd_cnt are captured at that edge.
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE, and no command SHALL be accepted in any other state.
REQ-016 On acceptance, the FSM SHALL go to LOAD for op LOAD or LOAD_SHR.
REQ-017 On acceptance, the FSM SHALL go to SHIFT for op SHR or SHL with cnt>0, with remaining=cnt.
REQ-018 On acceptance, the FSM SHALL go to DONE for op SHR or SHL with cnt=0.
REQ-019 LOAD SHALL last exactly one cycle with sel=11.
REQ-020 After LOAD, the FSM SHALL go to SHIFT if op is LOAD_SHR and cnt>0 (remaining=cnt), otherwise to DONE.
REQ-021 SHIFT SHALL drive sel=10 for SHL and sel=01 for SHR and LOAD_SHR.
REQ-022 SHIFT SHALL decrement remaining at each edge and go to DONE at the edge where remaining==1, so it lasts exactly cnt cycles.
REQ-023 DONE SHALL last one cycle with done=1 and sel=00, then return to IDLE.
REQ-024 sel, done and busy SHALL be registered outputs, glitch-free, valid for the whole cycle of their state.
REQ-025 sel SHALL be 00 in IDLE and DONE.
REQ-026 parin SHALL hold the captured cmd_data from the acceptance edge until the next acceptance, stable through LOAD.
REQ-027 mirror SHALL update at the edge ending each LOAD cycle to parin.
REQ-028 mirror SHALL update at the edge ending each SHR cycle to {0,mirror[3:1]}.
REQ-029 mirror SHALL update at the edge ending each SHL cycle to {mirror[2:0],0}.
REQ-030 mirror SHALL hold in all other cycles.
REQ-031 A LOAD command accepted at edge k SHALL give sel=11 in cycle k+1, done=1 in cycle k+2 and cmd_ready=1 in cycle k+3.
REQ-032 A shift-only command with count n>0 accepted at edge k SHALL give done=1 in cycle k+n+1.
REQ-033 A LOAD_SHR command with count n accepted at edge k SHALL give done=1 in cycle k+n+2.
REQ-034 Back-to-back commands SHALL be separated by at least one IDLE cycle.
REQ-035 cmd_valid held high SHALL be accepted on the first IDLE edge.
REQ-036 Changes on the cmd_* inputs after the acceptance edge SHALL have no effect on the command in progress.

Reset
REQ-037 When clr=0, the block SHALL immediately (asynchronously) force state=IDLE, sel=00, parin=0000, mirror=0000, remaining=0, done=0, busy=0 and cmd_ready=1.
REQ-038 Reset asserted mid-command SHALL abort that command with no done pulse.
REQ-039 After clr is released, the first command SHALL be accepted on the first rising edge where cmd_valid=1.

Verification
REQ-040 The bench SHALL cover: LOAD 1011 -> sel=11 for one cycle, mirror=1011, done pulse two cycles after acceptance.
REQ-041 The bench SHALL cover: LOAD_SHR data 1011 cnt 2 -> sel 11,01,01, then mirror=0010, done at k+4.
REQ-042 The bench SHALL cover: SHL cnt 3 from mirror 1011 -> sel=10 for three cycles, mirror=1000, done at k+4.
REQ-043 The bench SHALL cover: SHR cnt 0 -> no sel activity, mirror unchanged, done at k+1, cmd_ready back at k+2.
REQ-044 The bench SHALL cover: cmd_valid held high with two queued commands -> second accepted only after DONE, with one IDLE cycle between them.
REQ-045 The bench SHALL cover: clr pulsed low during SHIFT of an SHL cnt 7 -> outputs reset at once, no done pulse, next LOAD 0101 runs normally.
